// File: rtl/spi_cmd_if.sv
// Byte-stream input and register-write output bundle for the SPI command sequencer.
// The bench drives through master; the controller consumes through slave.
interface spi_cmd_if #(
  parameter int NUM_CH = 8
);
  logic              frame_active;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              pulse_we;
  logic [3:0]        pulse_addr;
  logic [15:0]       pulse_data;
  logic              en_we;
  logic [NUM_CH-1:0] en_data;
  logic [7:0]        status;
  logic [7:0]        err_cnt;

  modport master (
    output frame_active, byte_valid, byte_data,
    input  pulse_we, pulse_addr, pulse_data, en_we, en_data, status, err_cnt
  );

  modport slave (
    input  frame_active, byte_valid, byte_data,
    output pulse_we, pulse_addr, pulse_data, en_we, en_data, status, err_cnt
  );
endinterface

// File: rtl/spi_cmd_controller.sv
// Parses 4-byte CMD/D_HI/D_LO/CHK frames from the SPI byte stream and issues
// validated single-cycle writes to the servo pulse-width and enable registers.
module spi_cmd_controller #(
  parameter int          NUM_CH    = 8,
  parameter logic [15:0] MIN_PULSE = 16'd500,
  parameter logic [15:0] MAX_PULSE = 16'd2500
) (
  input logic     clk,
  input logic     rst_n,
  spi_cmd_if.slave bus
);

  typedef enum logic [2:0] {S_CMD, S_HI, S_LO, S_CHK, S_DRAIN} state_t;

  localparam logic [7:0] ST_OK    = 8'h01;
  localparam logic [7:0] ST_CSUM  = 8'h81;
  localparam logic [7:0] ST_OPC   = 8'h82;
  localparam logic [7:0] ST_CHAN  = 8'h83;
  localparam logic [7:0] ST_RANGE = 8'h84;
  localparam logic [7:0] ST_TRUNC = 8'h85;

  state_t            state_q, state_d;
  logic [7:0]        cmd_q, cmd_d, hi_q, hi_d, lo_q, lo_d;
  logic              pulse_we_q, pulse_we_d, en_we_q, en_we_d;
  logic [3:0]        pulse_addr_q, pulse_addr_d;
  logic [15:0]       pulse_data_q, pulse_data_d;
  logic [NUM_CH-1:0] en_data_q, en_data_d;
  logic [7:0]        status_q, status_d, err_cnt_q, err_cnt_d;
  logic [7:0]        code;
  logic [15:0]       frame_data;

  assign frame_data = {hi_q, lo_q};

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Checks are ordered so the first failing one determines the code.
  function automatic logic [7:0] eval_frame(input logic [7:0] cmd, input logic [7:0] hi,
                                            input logic [7:0] lo, input logic [7:0] chk);
    logic [15:0] data;
    data = {hi, lo};
    if (chk != (cmd ^ hi ^ lo ^ 8'hA5))                      return ST_CSUM;
    if (cmd[7:4] != 4'h1 && cmd[7:4] != 4'h2 && cmd[7:4] != 4'h3) return ST_OPC;
    if (cmd[7:4] == 4'h1 && {1'b0, cmd[3:0]} >= 5'(NUM_CH))     return ST_CHAN;
    if (cmd[7:4] == 4'h1 && (data < MIN_PULSE || data > MAX_PULSE)) return ST_RANGE;
    return ST_OK;
  endfunction

  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    pulse_we_d   = 1'b0;
    en_we_d      = 1'b0;
    pulse_addr_d = pulse_addr_q;
    pulse_data_d = pulse_data_q;
    en_data_d    = en_data_q;
    status_d     = status_q;
    err_cnt_d    = err_cnt_q;
    code         = 8'h00;

    // Losing SSEL wins over any coincident byte: the byte is dropped.
    if (!bus.frame_active) begin
      state_d = S_CMD;
      if (state_q == S_HI || state_q == S_LO || state_q == S_CHK) begin
        status_d  = ST_TRUNC;
        err_cnt_d = sat_inc(err_cnt_q);
      end
    end else if (bus.byte_valid) begin
      case (state_q)
        S_CMD: begin cmd_d = bus.byte_data; state_d = S_HI;  end
        S_HI:  begin hi_d  = bus.byte_data; state_d = S_LO;  end
        S_LO:  begin lo_d  = bus.byte_data; state_d = S_CHK; end
        S_CHK: begin
          code     = eval_frame(cmd_q, hi_q, lo_q, bus.byte_data);
          status_d = code;
          state_d  = S_DRAIN;
          if (code != ST_OK) begin
            err_cnt_d = sat_inc(err_cnt_q);
          end else if (cmd_q[7:4] == 4'h1) begin
            pulse_we_d   = 1'b1;
            pulse_addr_d = cmd_q[3:0];
            pulse_data_d = frame_data;
          end else if (cmd_q[7:4] == 4'h2) begin
            en_we_d   = 1'b1;
            en_data_d = frame_data[NUM_CH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_CMD;
      cmd_q        <= 8'h00;
      hi_q         <= 8'h00;
      lo_q         <= 8'h00;
      pulse_we_q   <= 1'b0;
      en_we_q      <= 1'b0;
      pulse_addr_q <= 4'h0;
      pulse_data_q <= 16'h0000;
      en_data_q    <= '0;
      status_q     <= 8'h00;
      err_cnt_q    <= 8'h00;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      pulse_we_q   <= pulse_we_d;
      en_we_q      <= en_we_d;
      pulse_addr_q <= pulse_addr_d;
      pulse_data_q <= pulse_data_d;
      en_data_q    <= en_data_d;
      status_q     <= status_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign bus.pulse_we   = pulse_we_q;
  assign bus.pulse_addr = pulse_addr_q;
  assign bus.pulse_data = pulse_data_q;
  assign bus.en_we      = en_we_q;
  assign bus.en_data    = en_data_q;
  assign bus.status     = status_q;
  assign bus.err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_spi_cmd_controller.sv
// Directed bench for spi_cmd_controller: hand-computed frames and expected results.
module tb_spi_cmd_controller;
  localparam int NUM_CH = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   exp_err = 0;

  spi_cmd_if #(.NUM_CH(NUM_CH)) ifc ();

  spi_cmd_controller #(.NUM_CH(NUM_CH), .MIN_PULSE(16'd500), .MAX_PULSE(16'd2500)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    ifc.byte_valid = 1'b1;
    ifc.byte_data  = b;
    tick();
    ifc.byte_valid = 1'b0;
    ifc.byte_data  = 8'h00;
  endtask

  task automatic close_frame();
    ifc.frame_active = 1'b0;
    tick();
  endtask

  // Sends a complete frame; checks outputs one edge after CHK, then that strobes drop.
  task automatic run_frame(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3,
                           input logic [7:0] exp_st, input logic exp_pwe, input logic exp_ewe);
    ifc.frame_active = 1'b1;
    send_byte(b0);
    send_byte(b1);
    send_byte(b2);
    send_byte(b3);
    if (exp_st != 8'h01) exp_err = (exp_err >= 255) ? 255 : exp_err + 1;
    check({tag, ".status"}, ifc.status, exp_st);
    check({tag, ".pulse_we"}, ifc.pulse_we, exp_pwe);
    check({tag, ".en_we"}, ifc.en_we, exp_ewe);
    check({tag, ".err_cnt"}, ifc.err_cnt, exp_err[7:0]);
    tick();
    check({tag, ".pulse_we_1cyc"}, ifc.pulse_we, 1'b0);
    check({tag, ".en_we_1cyc"}, ifc.en_we, 1'b0);
    close_frame();
  endtask

  initial begin
    ifc.frame_active = 1'b0;
    ifc.byte_valid   = 1'b0;
    ifc.byte_data    = 8'h00;
    tick();
    tick();
    rst_n = 1'b1;
    check("rst.status", ifc.status, 8'h00);
    check("rst.err_cnt", ifc.err_cnt, 8'h00);
    check("rst.pulse_we", ifc.pulse_we, 1'b0);
    check("rst.en_we", ifc.en_we, 1'b0);
    check("rst.en_data", ifc.en_data, 8'h00);
    check("rst.pulse_addr", ifc.pulse_addr, 4'h0);
    check("rst.pulse_data", ifc.pulse_data, 16'h0000);

    // Happy path: channel 2, 1500 us
    run_frame("set2", 8'h12, 8'h05, 8'hDC, 8'h6E, 8'h01, 1'b1, 1'b0);
    check("set2.addr", ifc.pulse_addr, 4'd2);
    check("set2.data", ifc.pulse_data, 16'd1500);

    // Range boundaries on channel 0
    run_frame("min", 8'h10, 8'h01, 8'hF4, 8'h40, 8'h01, 1'b1, 1'b0);
    check("min.addr", ifc.pulse_addr, 4'd0);
    check("min.data", ifc.pulse_data, 16'd500);
    run_frame("over", 8'h10, 8'h09, 8'hC5, 8'h79, 8'h84, 1'b0, 1'b0);
    check("over.hold", ifc.pulse_data, 16'd500);
    run_frame("max", 8'h10, 8'h09, 8'hC4, 8'h78, 8'h01, 1'b1, 1'b0);
    check("max.data", ifc.pulse_data, 16'd2500);
    run_frame("under", 8'h10, 8'h01, 8'hF3, 8'h47, 8'h84, 1'b0, 1'b0);

    // Enable and ping
    run_frame("en", 8'h20, 8'h00, 8'hA5, 8'h20, 8'h01, 1'b0, 1'b1);
    check("en.data", ifc.en_data, 8'hA5);
    run_frame("ping", 8'h30, 8'h00, 8'h00, 8'h95, 8'h01, 1'b0, 1'b0);
    check("ping.en_hold", ifc.en_data, 8'hA5);
    check("ping.data_hold", ifc.pulse_data, 16'd2500);

    // Decode errors
    run_frame("csum", 8'h12, 8'h05, 8'hDC, 8'h6F, 8'h81, 1'b0, 1'b0);
    run_frame("opc", 8'h52, 8'h00, 8'h00, 8'hF7, 8'h82, 1'b0, 1'b0);
    run_frame("chan", 8'h18, 8'h05, 8'hDC, 8'h64, 8'h83, 1'b0, 1'b0);

    // Truncation after 2 bytes, then a normal frame proves return to S_CMD
    ifc.frame_active = 1'b1;
    send_byte(8'h12);
    send_byte(8'h05);
    close_frame();
    exp_err++;
    check("trunc.status", ifc.status, 8'h85);
    check("trunc.err_cnt", ifc.err_cnt, exp_err[7:0]);
    run_frame("after_trunc", 8'h12, 8'h05, 8'hDC, 8'h6E, 8'h01, 1'b0 | 1'b1, 1'b0);

    // Empty frame from S_CMD: no status change
    ifc.frame_active = 1'b1;
    tick();
    close_frame();
    check("empty.status", ifc.status, 8'h01);
    check("empty.err_cnt", ifc.err_cnt, exp_err[7:0]);

    // Six-byte message: channel 3, 1000 us, then two ignored bytes
    ifc.frame_active = 1'b1;
    send_byte(8'h13);
    send_byte(8'h03);
    send_byte(8'hE8);
    send_byte(8'h5D);
    check("six.pulse_we", ifc.pulse_we, 1'b1);
    check("six.addr", ifc.pulse_addr, 4'd3);
    check("six.data", ifc.pulse_data, 16'd1000);
    send_byte(8'h10);
    check("six.extra5", ifc.pulse_we, 1'b0);
    send_byte(8'h01);
    check("six.extra6", ifc.pulse_we, 1'b0);
    close_frame();
    check("six.status", ifc.status, 8'h01);
    check("six.addr_hold", ifc.pulse_addr, 4'd3);

    // Byte coincident with frame_active=0 is dropped: 3 later bytes leave frame truncated
    ifc.byte_valid = 1'b1;
    ifc.byte_data  = 8'h12;
    tick();
    ifc.byte_valid = 1'b0;
    ifc.frame_active = 1'b1;
    send_byte(8'h05);
    send_byte(8'hDC);
    send_byte(8'h6E);
    check("coinc.no_strobe", ifc.pulse_we, 1'b0);
    check("coinc.status_hold", ifc.status, 8'h01);
    close_frame();
    exp_err++;
    check("coinc.status", ifc.status, 8'h85);
    check("coinc.err_cnt", ifc.err_cnt, exp_err[7:0]);

    // Saturation
    for (int i = 0; i < 260; i++) begin
      ifc.frame_active = 1'b1;
      send_byte(8'h12);
      send_byte(8'h05);
      send_byte(8'hDC);
      send_byte(8'h6F);
      close_frame();
      if (i == 100) check("sat.mid", ifc.err_cnt, exp_err[7:0] + 8'd101);
    end
    check("sat.err_cnt", ifc.err_cnt, 8'hFF);
    check("sat.status", ifc.status, 8'h81);

    // Reset mid-frame
    ifc.frame_active = 1'b1;
    send_byte(8'h12);
    send_byte(8'h05);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mrst.status", ifc.status, 8'h00);
    check("mrst.err_cnt", ifc.err_cnt, 8'h00);
    check("mrst.en_data", ifc.en_data, 8'h00);
    check("mrst.pulse_addr", ifc.pulse_addr, 4'h0);
    check("mrst.pulse_data", ifc.pulse_data, 16'h0000);
    close_frame();
    check("mrst.idle_status", ifc.status, 8'h00);
    exp_err = 0;
    run_frame("post_rst", 8'h12, 8'h05, 8'hDC, 8'h6E, 8'h01, 1'b1, 1'b0);
    check("post_rst.data", ifc.pulse_data, 16'd1500);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_cmd_controller.md
Name: spi_cmd_controller

Overview:
Command sequencer between the SPI slave receiver and the servo channel registers. Consumes the byte stream, one byte per `byte_valid` pulse, within SSEL-framed messages. Parses fixed 4-byte command frames, validates them, and issues single-cycle write strobes for pulse width or channel enables. Keeps a status code and an error count for host readback.

Parameters:
NUM_CH, 8, number of servo channels (1..16); sets pulse_addr width 4 and en_data width.
MIN_PULSE, 500, lowest legal pulse width in us (16-bit).
MAX_PULSE, 2500, highest legal pulse width in us (16-bit).

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
frame_active  in  1  synchronized SSEL active level (1 = inside message)
byte_valid  in  1  one-cycle pulse: byte_data holds a newly received byte
byte_data  in  8  received byte, MSB-first assembled
pulse_we  out  1  one-cycle write strobe for a pulse width register
pulse_addr  out  4  channel index for pulse_we
pulse_data  out  16  pulse width in us
en_we  out  1  one-cycle write strobe for the enable mask
en_data  out  NUM_CH  channel enable mask (bit n = channel n)
status  out  8  result code of the last completed or aborted frame
err_cnt  out  8  saturating count of rejected frames

Behaviour:
- Frame format: CMD, D_HI, D_LO, CHK. CMD[7:4] = opcode, CMD[3:0] = channel.
- Checksum rule: CHK == CMD ^ D_HI ^ D_LO ^ 8'hA5.
- Opcodes:
  - 0x1 SET_PULSE: data = {D_HI,D_LO}.
  - 0x2 SET_ENABLE: mask = {D_HI,D_LO}[NUM_CH-1:0]; channel field ignored.
  - 0x3 PING: no write.
  - All others are illegal.
- FSM states: S_CMD, S_HI, S_LO, S_CHK, S_DRAIN. Reset state is S_CMD.
- Transitions:
  - On a byte_valid cycle with frame_active=1: S_CMD→S_HI, S_HI→S_LO, S_LO→S_CHK (each latches its byte).
  - S_CHK→S_DRAIN: evaluate the frame.
  - S_DRAIN: ignore all further bytes until frame_active=0.
- Evaluation at the CHK byte, first failing check wins:
  - checksum mismatch → 0x81
  - illegal opcode → 0x82
  - SET_PULSE with channel ≥ NUM_CH → 0x83
  - SET_PULSE with data < MIN_PULSE or data > MAX_PULSE (inclusive bounds legal) → 0x84
  - otherwise → 0x01 (OK)
- Successful frame: SET_PULSE asserts pulse_we; SET_ENABLE asserts en_we. Latency: status, the strobe and its addr/data are all updated at the clock edge after the byte_valid cycle carrying CHK. Strobe high exactly 1 cycle. A rejected frame produces no strobe.
- Holding of outputs: pulse_addr, pulse_data and en_data hold their last values between strobes.
- Abort: frame_active=0 in any state returns the FSM to S_CMD next cycle.
  - If the state was S_HI, S_LO or S_CHK: status=0x85 (truncated) and err_cnt increments.
  - From S_CMD or S_DRAIN: no status change.
- Simultaneous events: byte_valid with frame_active=0 in the same cycle means the byte is discarded and the abort rule applies.
- Error count: every non-0x01 status increments err_cnt by 1, saturating at 8'hFF (no wrap).
- Back-to-back: a new frame requires frame_active to drop and rise again; bytes beyond the 4th are ignored.
- Reset (synchronous, rst_n=0 at a clk edge, any state including mid-frame):
  - state=S_CMD, pulse_we=0, en_we=0, pulse_addr=0, pulse_data=0.
  - en_data=0 (all channels disabled), status=8'h00, err_cnt=0.
  - Latched frame bytes cleared.

Test Plan:
- SET_PULSE happy path: frame 12 05 DC 6E → pulse_we for 1 cycle one clk after the CHK byte, pulse_addr=2, pulse_data=1500, status=0x01, err_cnt=0.
- Range boundaries on channel 0:
  - data 500 (10 01 F4 40) → accepted.
  - data 2501 (10 09 C5 79) → status=0x84, no strobe, err_cnt=1.
  - data 2500 (10 09 C4 78) → accepted.
- SET_ENABLE and PING:
  - 20 00 A5 20 → en_we=1, en_data=0xA5, status=0x01.
  - 30 00 00 95 → status=0x01, no strobe.
- Checksum and decode errors, with err_cnt incrementing each time:
  - 12 05 DC 6F → 0x81.
  - 52 00 00 F7 → 0x82.
  - 18 05 DC 64 (channel 8, NUM_CH=8) → 0x83.
- Truncation and drain:
  - frame_active drops after 2 bytes → status=0x85, FSM back in S_CMD.
  - 6-byte message whose first 4 bytes are valid → exactly one strobe; extra bytes ignored.
  - byte_valid coincident with frame_active=0 → byte discarded.
- Saturation and reset:
  - 260 bad-checksum frames → err_cnt=0xFF.
  - Assert rst_n=0 mid-frame → all outputs return to reset values; the next valid frame is accepted normally.
